// File: rtl/ula_sequencial_n.sv
// ula_sequencial_n: N-bit ALU with one-cycle add/sub/logic, iterative shift-add MUL and restoring DIV.
// Define ULA_BCD_EN to append a double-dabble stage and expose bcd_out.
module ula_sequencial_n #(
  parameter int WIDTH      = 8,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic [WIDTH-1:0]        A_in,
  input  logic [WIDTH-1:0]        B_in,
  input  logic                    Cin,
  input  logic [2:0]              OP_sel,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [2*WIDTH-1:0]      result,
  output logic                    LED_Cout,
  output logic                    LED_OV,
  output logic                    LED_Z,
  output logic                    LED_ERR
`ifdef ULA_BCD_EN
  ,
  output logic [4*BCD_DIGITS-1:0] bcd_out
`endif
);

  localparam int CW = $clog2(2*WIDTH+1);
  localparam logic [CW-1:0] CNT_CALC = CW'(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;

`ifdef ULA_BCD_EN
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_BCD, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`endif

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 cin_q, cin_d;
  logic [2:0]           op_q, op_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 cout_q, cout_d, ov_q, ov_d, z_q, z_d, err_q, err_d;

  logic [WIDTH:0]       sum, diff, mul_sum, div_sh;
  logic [WIDTH-1:0]     div_tr;
  logic                 div_ge, iter, work_q;
  logic [2*WIDTH-1:0]   fin_res;
  logic                 fin_cout, fin_ov, fin_z, fin_err;

`ifdef ULA_BCD_EN
  localparam logic [CW-1:0] CNT_BCD = CW'(2*WIDTH-1);
  logic [2*WIDTH-1:0]      bin_q, bin_d, pres_q, pres_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, bcdo_q, bcdo_d, bcd_adj, bcd_sh;
  logic                    pcout_q, pcout_d, pov_q, pov_d, pz_q, pz_d, perr_q, perr_d;

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    bcd_sh = {bcd_adj[4*BCD_DIGITS-2:0], bin_q[2*WIDTH-1]};
  end

  assign bcd_out = bcdo_q;
`else
  // BCD_DIGITS only sizes the optional converter; nothing to build here.
  if (BCD_DIGITS < 1) begin : g_no_bcd
  end
`endif

  // One shift-add step (hi:lo holds partial product, multiplier in lo) and one
  // restoring-division step (hi = partial remainder, lo = dividend/quotient).
  always_comb begin
    mul_sum = {1'b0, hi_q} + ({(WIDTH+1){lo_q[0]}} & {1'b0, a_q});
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, b_q};
    div_tr  = div_sh[WIDTH-1:0] - b_q;
    iter    = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
  end

  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    diff     = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
    fin_res  = '0;
    fin_cout = 1'b0;
    fin_ov   = 1'b0;
    fin_err  = 1'b0;
    case (op_q)
      OP_ADD: begin
        fin_res  = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        fin_cout = sum[WIDTH];
        fin_ov   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        fin_res  = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
        fin_cout = diff[WIDTH];
        fin_ov   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: fin_res = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:  fin_res = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR: fin_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_MUL: fin_res = {hi_q, lo_q};
      OP_DIV: begin
        if (b_q == '0) fin_err = 1'b1;
        else           fin_res = {hi_q, lo_q};
      end
      default: fin_res = '0;
    endcase
    fin_z = (fin_res == '0);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    cout_d   = cout_q;
    ov_d     = ov_q;
    z_d      = z_q;
    err_d    = err_q;
`ifdef ULA_BCD_EN
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    bcdo_d   = bcdo_q;
    pres_d   = pres_q;
    pcout_d  = pcout_q;
    pov_d    = pov_q;
    pz_d     = pz_q;
    perr_d   = perr_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d     = A_in;
          b_d     = B_in;
          cin_d   = Cin;
          op_d    = OP_sel;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = (OP_sel == OP_MUL) ? B_in : A_in;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (iter && (cnt_q != CNT_CALC)) begin
          cnt_d = cnt_q + CW'(1);
          if (op_q == OP_MUL) begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_d = div_ge ? div_tr : div_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
          end
        end else begin
`ifdef ULA_BCD_EN
          pres_d  = fin_res;
          pcout_d = fin_cout;
          pov_d   = fin_ov;
          pz_d    = fin_z;
          perr_d  = fin_err;
          bin_d   = fin_res;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_BCD;
`else
          result_d = fin_res;
          cout_d   = fin_cout;
          ov_d     = fin_ov;
          z_d      = fin_z;
          err_d    = fin_err;
          state_d  = S_DONE;
`endif
        end
      end
`ifdef ULA_BCD_EN
      S_BCD: begin
        bcd_d = bcd_sh;
        bin_d = {bin_q[2*WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_BCD) begin
          result_d = pres_q;
          cout_d   = pcout_q;
          ov_d     = pov_q;
          z_d      = pz_q;
          err_d    = perr_q;
          bcdo_d   = bcd_sh;
          state_d  = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // busy rises one edge after acceptance and drops on the edge that raises done
    work_q = (state_q != S_IDLE) && (state_q != S_DONE);
    busy_d = work_q && (state_d != S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      op_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ov_q     <= 1'b0;
      z_q      <= 1'b0;
      err_q    <= 1'b0;
`ifdef ULA_BCD_EN
      bin_q    <= '0;
      bcd_q    <= '0;
      bcdo_q   <= '0;
      pres_q   <= '0;
      pcout_q  <= 1'b0;
      pov_q    <= 1'b0;
      pz_q     <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ov_q     <= ov_d;
      z_q      <= z_d;
      err_q    <= err_d;
`ifdef ULA_BCD_EN
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      bcdo_q   <= bcdo_d;
      pres_q   <= pres_d;
      pcout_q  <= pcout_d;
      pov_q    <= pov_d;
      pz_q     <= pz_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign LED_Cout = cout_q;
  assign LED_OV   = ov_q;
  assign LED_Z    = z_q;
  assign LED_ERR  = err_q;

endmodule

// File: tb/tb_ula_sequencial_n.sv
// Scoreboard bench for ula_sequencial_n (WIDTH=8): behavioural model pushes expectations at start,
// popped and compared when done pulses.
module tb_ula_sequencial_n;
  localparam int W = 8;
  localparam int D = 5;

  logic           CLK = 1'b0;
  logic           RST_n;
  logic [W-1:0]   A_in, B_in;
  logic           Cin;
  logic [2:0]     OP_sel;
  logic           start;
  logic           busy, done;
  logic [2*W-1:0] result;
  logic           LED_Cout, LED_OV, LED_Z, LED_ERR;
`ifdef ULA_BCD_EN
  logic [4*D-1:0] bcd_out;
`endif

  ula_sequencial_n #(.WIDTH(W), .BCD_DIGITS(D)) dut (
    .CLK(CLK), .RST_n(RST_n), .A_in(A_in), .B_in(B_in), .Cin(Cin), .OP_sel(OP_sel),
    .start(start), .busy(busy), .done(done), .result(result),
    .LED_Cout(LED_Cout), .LED_OV(LED_OV), .LED_Z(LED_Z), .LED_ERR(LED_ERR)
`ifdef ULA_BCD_EN
    , .bcd_out(bcd_out)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2*W-1:0] res;
    logic           cout, ov, z, err;
    int             lat;
  } exp_t;

  exp_t           sb_q[$];
  int             n_vec = 0;
  int             n_err = 0;
  logic [2*W-1:0] prev_res = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input int a, input int b, input int c, input int op);
    exp_t e;
    int s, sa, sb;
    e.res = '0; e.cout = 1'b0; e.ov = 1'b0; e.err = 1'b0; e.lat = 1;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0: begin
        s = a + b + c;
        e.res = 16'(s % 256); e.cout = (s > 255);
        e.ov = (sa + sb + c > 127) || (sa + sb + c < -128);
      end
      1: begin
        s = a - b - c;
        e.res = 16'((s + 512) % 256); e.cout = (a < b + c);
        e.ov = (sa - sb - c > 127) || (sa - sb - c < -128);
      end
      2: e.res = 16'(a & b);
      3: e.res = 16'(a | b);
      4: e.res = 16'(a ^ b);
      5: begin e.res = 16'(a * b); e.lat = W + 1; end
      6: begin
        if (b == 0) e.err = 1'b1;
        else begin e.res = 16'((a % b) * 256 + a / b); e.lat = W + 1; end
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
`ifdef ULA_BCD_EN
    e.lat = e.lat + 2*W;
`endif
    return e;
  endfunction

  // Drives one request at the current negedge; returns at the negedge where done is seen.
  task automatic run_op(input int a, input int b, input int c, input int op, input bit poke);
    exp_t g;
    int lat, nb;
    sb_q.push_back(model(a, b, c, op));
    A_in = 8'(a); B_in = 8'(b); Cin = 1'(c); OP_sel = 3'(op); start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    A_in = 8'($urandom); B_in = 8'($urandom); Cin = 1'($urandom); OP_sel = 3'($urandom);
    lat = 0; nb = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (!done) begin
        if (busy) nb++;
        chk("hold", 32'(result), 32'(prev_res));
        start = poke && busy;
        if (start) begin A_in = 8'($urandom); B_in = 8'($urandom); OP_sel = 3'd0; end
      end
    end while (!done && lat < 200);
    start = 1'b0;
    if (!done) chk("done_timeout", 32'(done), 32'(1));
    g = sb_q.pop_front();
    chk("latency", 32'(lat), 32'(g.lat));
    chk("busy_cycles", 32'(nb), 32'(g.lat - 1));
    chk("busy_at_done", 32'(busy), 32'(0));
    chk("result", 32'(result), 32'(g.res));
    chk("cout", 32'(LED_Cout), 32'(g.cout));
    chk("ov", 32'(LED_OV), 32'(g.ov));
    chk("z", 32'(LED_Z), 32'(g.z));
    chk("err", 32'(LED_ERR), 32'(g.err));
`ifdef ULA_BCD_EN
    chk("bcd", 32'(bcd_out), 32'(to_bcd(int'(g.res))));
`endif
    prev_res = g.res;
  endtask

  initial begin
    int nd, a, b, op;
    RST_n = 1'b0; start = 1'b0; A_in = '0; B_in = '0; Cin = 1'b0; OP_sel = '0;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_flags", 32'({LED_Cout, LED_OV, LED_Z, LED_ERR}), 32'(0));
`ifdef ULA_BCD_EN
    chk("rst_bcd", 32'(bcd_out), 32'(0));
`endif

    run_op(200, 100, 0, 0, 0);
    run_op(8'h80, 1, 0, 1, 0);
    run_op(5, 5, 0, 1, 0);
    run_op(8'h7F, 0, 1, 0, 0);
    run_op(3, 3, 1, 1, 0);
    run_op(255, 0, 1, 0, 0);
    run_op(8'hF0, 8'h3C, 0, 2, 0);
    run_op(8'hF0, 8'h3C, 0, 3, 0);
    run_op(8'hF0, 8'h3C, 0, 4, 0);
    run_op(8'hAA, 8'h55, 1, 7, 0);
    run_op(255, 255, 0, 5, 1);
    run_op(13, 11, 0, 5, 1);
    run_op(0, 77, 0, 5, 0);
    repeat (2) @(negedge CLK);
    run_op(200, 7, 0, 6, 1);
    run_op(9, 0, 0, 6, 0);
    run_op(5, 9, 0, 6, 0);
    run_op(255, 1, 0, 6, 0);
    run_op(255, 255, 0, 6, 0);

    // Abort a multiply with reset: no done pulse, everything cleared.
    A_in = 8'd3; B_in = 8'd7; OP_sel = 3'd5; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    RST_n = 1'b0;
    @(negedge CLK);
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_result", 32'(result), 32'(0));
    chk("abort_flags", 32'({LED_Cout, LED_OV, LED_Z, LED_ERR}), 32'(0));
    RST_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge CLK);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'(0));
    prev_res = '0;
    run_op(1, 1, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      a  = int'($urandom_range(0, 255));
      b  = (i % 5 == 0) ? 0 : int'($urandom_range(0, 255));
      op = int'($urandom_range(0, 7));
      if (i % 4 == 1) repeat (1) @(negedge CLK);
      run_op(a, b, int'($urandom_range(0, 1)), op, (i % 3 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
